fetch_unit: RTL and testbench

//  Instruction fetch stage upstream of the CPU decode/execute datapath.

---
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, 1-cycle imem read issue, prefetch FIFO and redirect flush.
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [INST_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pcs_q  [DEPTH];
    logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, infl_pc_q, infl_pc_d;
    logic              infl_q, infl_d;
    logic              pop, push, issue;
    logic [CW:0]       credit;

    // Credit counts the in-flight word as occupied so a full FIFO can never overflow.
    always_comb begin
        inst_valid = (cnt_q != '0) && !redirect;
        inst       = data_q[rd_q];
        inst_pc    = pcs_q[rd_q];
        pop        = inst_valid && inst_ready;
        push       = infl_q && !redirect;
        credit     = {1'b0, cnt_q} + (CW+1)'(infl_q) - (CW+1)'(pop);
        issue      = redirect || (credit < (CW+1)'(DEPTH));
        imem_req   = issue && !reset;
        imem_addr  = redirect ? redirect_pc : fetch_pc_q;
        fetch_pc_d = issue ? imem_addr + ADDR_W'(1) : fetch_pc_q;
        infl_d     = issue;
        infl_pc_d  = issue ? imem_addr : infl_pc_q;
        cnt_d      = redirect ? '0 : cnt_q + CW'(push) - CW'(pop);
        rd_d       = redirect ? '0 : rd_q + PW'(pop);
        wr_d       = redirect ? '0 : wr_q + PW'(push);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            infl_q     <= 1'b0;
            infl_pc_q  <= '0;
            fetch_pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pcs_q[i]  <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            infl_q     <= infl_d;
            infl_pc_q  <= infl_pc_d;
            fetch_pc_q <= fetch_pc_d;
            if (push) begin
                data_q[wr_q] <= imem_rdata;
                pcs_q[wr_q]  <= infl_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of startup, backpressure, redirect, wrap and async reset.
module tb_fetch_unit;
    logic        clk, reset, imem_req, redirect, inst_valid, inst_ready;
    logic [15:0] imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
    int          n_chk = 0, n_pass = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: mem[a] = a ^ 16'hA000, one cycle read latency.
    always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ 16'hA000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic expect_inst(input string tag, input logic [15:0] pc);
        check({tag, " valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, " pc"}, {16'd0, inst_pc}, {16'd0, pc});
        check({tag, " inst"}, {16'd0, inst}, {16'd0, pc ^ 16'hA000});
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        redirect = 1'b0;
        inst_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        #2;
        check("rst req", {31'd0, imem_req}, 32'd0);
        check("rst valid", {31'd0, inst_valid}, 32'd0);
        check("rst inst", {16'd0, inst}, 32'd0);
        check("rst pc", {16'd0, inst_pc}, 32'd0);

        // 1: streaming from reset
        do_reset();
        inst_ready = 1'b1;
        sample();
        check("t1 c0 req", {31'd0, imem_req}, 32'd1);
        check("t1 c0 addr", {16'd0, imem_addr}, 32'd0);
        check("t1 c0 valid", {31'd0, inst_valid}, 32'd0);
        tick(); sample();
        check("t1 c1 valid", {31'd0, inst_valid}, 32'd0);
        check("t1 c1 addr", {16'd0, imem_addr}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick(); sample();
            expect_inst("t1 stream", 16'(k));
        end

        // 2: backpressure fills FIFO, then drain
        do_reset();
        for (int k = 0; k < 6; k++) begin
            sample();
            if (k < 5) tick();
        end
        check("t2 full req", {31'd0, imem_req}, 32'd0);
        check("t2 fetch_pc", {16'd0, imem_addr}, 32'd2);
        expect_inst("t2 held", 16'd0);
        tick();
        inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            expect_inst("t2 drain", 16'(k));
            tick();
        end

        // 3: FIFO full with pc 3,4 then redirect
        inst_ready = 1'b0;
        sample(); expect_inst("t3 head", 16'd3);
        tick(); sample();
        expect_inst("t3 stable", 16'd3);
        check("t3 full req", {31'd0, imem_req}, 32'd0);
        tick();
        redirect = 1'b1; redirect_pc = 16'h0040; inst_ready = 1'b1;
        sample();
        check("t3 redir valid", {31'd0, inst_valid}, 32'd0);
        check("t3 redir req", {31'd0, imem_req}, 32'd1);
        check("t3 redir addr", {16'd0, imem_addr}, 32'h40);
        tick();
        redirect = 1'b0;
        sample();
        check("t3 n1 valid", {31'd0, inst_valid}, 32'd0);
        check("t3 n1 addr", {16'd0, imem_addr}, 32'h41);
        for (int k = 0; k < 3; k++) begin
            tick(); sample();
            expect_inst("t3 after", 16'h0040 + 16'(k));
        end

        // 4: redirect coincident with a would-be transfer (pc 0x43 at head)
        tick();
        redirect = 1'b1; redirect_pc = 16'h0100;
        sample();
        check("t4 redir valid", {31'd0, inst_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        sample();
        check("t4 n1 valid", {31'd0, inst_valid}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick(); sample();
            expect_inst("t4 after", 16'h0100 + 16'(k));
        end

        // 5: redirect to top of address space wraps
        tick();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        sample();
        check("t5 redir valid", {31'd0, inst_valid}, 32'd0);
        tick();
        redirect = 1'b0;
        sample();
        for (int k = 0; k < 3; k++) begin
            tick(); sample();
            expect_inst("t5 wrap", 16'hFFFF + 16'(k));
        end

        // 6: asynchronous reset between edges
        tick();
        #2;
        check("t6 pre valid", {31'd0, inst_valid}, 32'd1);
        check("t6 pre req", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6 async valid", {31'd0, inst_valid}, 32'd0);
        check("t6 async req", {31'd0, imem_req}, 32'd0);
        check("t6 async pc", {16'd0, inst_pc}, 32'd0);
        tick();
        reset = 1'b0;
        sample();
        check("t6 c0 addr", {16'd0, imem_addr}, 32'd0);
        tick(); sample();
        check("t6 c1 valid", {31'd0, inst_valid}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick(); sample();
            expect_inst("t6 restart", 16'(k));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
